// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared definitions for the multiply/divide sequencer: the
//             datapath width, the operation encoding seen on the op port
//             and the sequencer state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   localparam int MULDIV_XLEN = 32;

   // Values of the 3-bit op port; the three codes not listed here are
   // unsupported and complete through the fast path with a zero result.
   typedef enum logic [2:0] {
      OP_MUL  = 3'b000,
      OP_DIV  = 3'b100,
      OP_DIVU = 3'b101,
      OP_REM  = 3'b110,
      OP_REMU = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Purpose  : One iteration of the sequencer datapath, purely combinational.
//             MUL  : shift-add, acc += x when y[0]; x <<= 1; y >>= 1.
//             DIV  : restoring step, the partial remainder in acc absorbs the
//                    next dividend bit from the top of x, and the quotient
//                    bit is shifted into the bottom of x; y holds the divisor.
//  Ports    : is_mul              - select shift-add (1) or division (0)
//             acc, x, y           - current working registers
//             acc_next, x_next,
//             y_next              - working registers after one iteration
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
   parameter int W = 32
) (
   input  logic         is_mul,
   input  logic [W-1:0] acc,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] acc_next,
   output logic [W-1:0] x_next,
   output logic [W-1:0] y_next
);

   logic [W:0] shifted;
   logic [W:0] diff;

   always_comb begin
      shifted  = {acc, x[W-1]};
      diff     = shifted - {1'b0, y};
      acc_next = acc;
      x_next   = x;
      y_next   = y;
      if (is_mul) begin
         acc_next = acc + (y[0] ? x : '0);
         x_next   = x << 1;
         y_next   = y >> 1;
      end else if (!diff[W]) begin
         // Partial remainder covers the divisor: keep the difference.
         acc_next = diff[W-1:0];
         x_next   = {x[W-2:0], 1'b1};
      end else begin
         // Restore: keep the shifted remainder, quotient bit is 0.
         acc_next = shifted[W-1:0];
         x_next   = {x[W-2:0], 1'b0};
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative 32-bit MUL / DIV / DIVU / REM / REMU unit. Operands
//             are captured on the accept edge, 32 iterations run in CALC, and
//             the result is published with a one-cycle done pulse on the edge
//             that leaves FIN. Divide-by-zero, signed overflow and
//             unsupported opcodes skip CALC and finish one edge after accept.
//  Ports    : clk, reset         - clock, asynchronous active-high reset
//             start              - request, held by the core until done
//             kill               - abort any in-flight operation
//             op                 - operation code (see muldiv_pkg::op_e)
//             a, b               - dividend/multiplicand, divisor/multiplier
//             busy               - operation in progress (CALC or FIN)
//             done               - one-cycle result-valid pulse
//             result             - result, held until the next completion
//             stall              - start & ~done, holds the core's PC
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = MULDIV_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            stall
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state;
   logic [5:0]      count;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] x;
   logic [XLEN-1:0] y;
   logic            mul_q;
   logic            rem_q;
   logic            neg_quo;
   logic            neg_rem;
   logic            fast_q;
   logic [XLEN-1:0] fast_val_q;

   // Decode of the live request, only used on the accept edge
   logic            mul_op;
   logic            div_op;
   logic            signed_op;
   logic            rem_op;
   logic            div_zero;
   logic            overflow;
   logic            fast;
   logic [XLEN-1:0] fast_val;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;

   logic [XLEN-1:0] acc_next;
   logic [XLEN-1:0] x_next;
   logic [XLEN-1:0] y_next;
   logic [XLEN-1:0] final_val;

   assign stall = start & ~done;

   always_comb begin
      mul_op    = (op == OP_MUL);
      div_op    = op[2];
      signed_op = op[2] & ~op[0];
      rem_op    = op[2] & op[1];
      div_zero  = div_op & (b == '0);
      overflow  = signed_op & (a == MIN_NEG) & (b == '1);
      fast      = ~(mul_op | div_op) | div_zero | overflow;
      a_neg     = signed_op & a[XLEN-1];
      b_neg     = signed_op & b[XLEN-1];
      abs_a     = a_neg ? -a : a;
      abs_b     = b_neg ? -b : b;
      fast_val  = '0;
      if (div_zero)
         fast_val = rem_op ? a : '1;
      else if (overflow)
         fast_val = rem_op ? '0 : MIN_NEG;
   end

   muldiv_step #(
      .W        (XLEN)
   ) u_step (
      .is_mul   (mul_q),
      .acc      (acc),
      .x        (x),
      .y        (y),
      .acc_next (acc_next),
      .x_next   (x_next),
      .y_next   (y_next)
   );

   // Sign fix-up of the magnitude results: quotient negated when operand
   // signs differ, remainder follows the sign of the dividend.
   always_comb begin
      if (fast_q)
         final_val = fast_val_q;
      else if (mul_q)
         final_val = acc;
      else if (rem_q)
         final_val = neg_rem ? -acc : acc;
      else
         final_val = neg_quo ? -x : x;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         acc        <= '0;
         x          <= '0;
         y          <= '0;
         mul_q      <= 1'b0;
         rem_q      <= 1'b0;
         neg_quo    <= 1'b0;
         neg_rem    <= 1'b0;
         fast_q     <= 1'b0;
         fast_val_q <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // done is still high in the cycle after completion; the held
               // start of the finished request must not be taken again.
               if (start && !kill && !done) begin
                  count      <= '0;
                  mul_q      <= mul_op;
                  rem_q      <= rem_op;
                  neg_quo    <= a_neg ^ b_neg;
                  neg_rem    <= a_neg;
                  fast_q     <= fast;
                  fast_val_q <= fast_val;
                  acc        <= '0;
                  x          <= mul_op ? a : abs_a;
                  y          <= mul_op ? b : abs_b;
                  busy       <= 1'b1;
                  state      <= fast ? FIN : CALC;
               end
            end
            CALC: begin
               if (kill) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc   <= acc_next;
                  x     <= x_next;
                  y     <= y_next;
                  count <= count + 6'd1;
                  if (count == 6'd31)
                     state <= FIN;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (!kill) begin
                  done   <= 1'b1;
                  result <= final_val;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer: directed cases plus
//             randomized operations compared with an arithmetic model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        kill;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        stall;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int done_pulses = 0;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .stall  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_pulses <= done_pulses + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Arithmetic model of the required results.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic ovf;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (o)
         3'b000:  return x * y;
         3'b100:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y));
         3'b101:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110:  return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
         3'b111:  return (y == 0) ? x : x % y;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      if (o != 3'b000 && !o[2]) return 1;
      if (o[2] && y == 0) return 1;
      if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issues one request at posedge+1; the next edge is E0. Returns the
   // number of edges from E0 to the first sample showing done.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit hold);
      int          lat;
      bit          seen;
      logic [31:0] res;
      lat = 0; seen = 0; res = '0;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_busy_e0"}, {31'b0, busy}, 32'd1);
      // Operand changes after acceptance must not matter.
      op = 3'($urandom); a = $urandom; b = $urandom;
      for (int i = 1; i <= 40; i++) begin
         if (!done) begin
            if (i > 1) check({tag, "_stall"}, {31'b0, stall}, 32'd1);
            @(posedge clk); #1;
            if (done) begin lat = i; seen = 1; res = result; end
         end
      end
      check({tag, "_seen"}, {31'b0, seen}, 32'd1);
      check({tag, "_lat"}, lat, model_latency(o, x, y));
      check({tag, "_res"}, res, model(o, x, y));
      check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
      if (!hold) start = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_one_pulse"}, {31'b0, done}, 32'd0);
      check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
      check({tag, "_result_hold"}, result, res);
   endtask

   task automatic check_const(input string tag, input logic [31:0] exp);
      check(tag, result, exp);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
      #2;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases with spec-given constants
      run_op("mul7x6", 3'b000, 32'd7, 32'd6, 1'b0);            check_const("mul7x6_k", 32'h2A);
      run_op("mulff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); check_const("mulff_k", 32'h1);
      run_op("div_m7", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);    check_const("div_m7_k", 32'hFFFF_FFFD);
      run_op("rem_m7", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);    check_const("rem_m7_k", 32'hFFFF_FFFF);
      run_op("divu_m7", 3'b101, 32'hFFFF_FFF9, 32'd2, 1'b0);   check_const("divu_m7_k", 32'h7FFF_FFFC);
      run_op("remu_m7", 3'b111, 32'hFFFF_FFF9, 32'd2, 1'b0);   check_const("remu_m7_k", 32'h1);
      run_op("div0", 3'b100, 32'd5, 32'd0, 1'b0);              check_const("div0_k", 32'hFFFF_FFFF);
      run_op("remu0", 3'b111, 32'd5, 32'd0, 1'b0);             check_const("remu0_k", 32'h5);
      run_op("ovf_div", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); check_const("ovf_div_k", 32'h8000_0000);
      run_op("ovf_rem", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); check_const("ovf_rem_k", 32'h0);
      run_op("bad_op", 3'b010, 32'd9, 32'd3, 1'b0);            check_const("bad_op_k", 32'h0);
      // start left high through the done cycle must not be re-accepted
      run_op("hold", 3'b101, 32'd100, 32'd7, 1'b1);

      // Kill at step 10 of a DIV
      pulses = done_pulses;
      op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1; kill = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check("kill_no_done", done_pulses, pulses);
      run_op("mul3x4", 3'b000, 32'd3, 32'd4, 1'b0);            check_const("mul3x4_k", 32'hC);

      // Kill in IDLE blocks acceptance that cycle
      op = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      check("kill_idle", {31'b0, busy}, 32'd0);

      // Reset at step 20
      pulses = done_pulses;
      op = 3'b000; a = 32'd11; b = 32'd13; start = 1'b1;
      @(posedge clk); #1;
      repeat (20) @(posedge clk);
      #1; reset = 1'b1;
      #1;
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_no_done", done_pulses, pulses);
      run_op("after_rst", 3'b000, 32'd11, 32'd13, 1'b0);

      // Randomized operations
      for (int n = 0; n < 30; n++) begin
         logic [2:0]  ro;
         logic [31:0] ra;
         logic [31:0] rb;
         int          sel;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (sel < 4) rb = 32'($urandom_range(1, 20));
         if (sel == 4) ra = -ra;
         run_op("rand", ro, ra, rb, 1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
